// File: rtl/lfsr_axi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_axi_sequencer
// Brief    : Programs an AXI-Lite LFSR peripheral, then streams its samples.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_axi_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [7:0]            cfg_seed,
  input  logic [7:0]            cfg_taps,
  input  logic [7:0]            cfg_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA, S_PUSH, S_FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_ADDR_CTRL = ADDR_WIDTH'(4'h0);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_SEED = ADDR_WIDTH'(4'h4);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_TAPS = ADDR_WIDTH'(4'h8);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_DATA = ADDR_WIDTH'(4'hC);
  localparam logic [2:0]            c_STEP_ENABLE = 3'd3;
  localparam logic [2:0]            c_STEP_STOP   = 3'd4;

  state_t          r_state;
  logic [2:0]      r_wstep;
  logic [7:0]      r_seed;
  logic [7:0]      r_count;
  logic [7:0]      r_sample_cnt;

  logic [2:0]            w_nxt_step;
  logic [ADDR_WIDTH-1:0] w_nxt_addr;
  logic [DATA_WIDTH-1:0] w_nxt_data;
  logic                  w_aw_ok;
  logic                  w_w_ok;
  logic [7:0]            w_cnt_inc;

  // Step 0 (taps) is issued straight from the start inputs; this mux covers steps 1..4.
  always_comb begin
    w_nxt_step = r_wstep + 3'd1;
    w_nxt_addr = c_ADDR_CTRL;
    w_nxt_data = '0;
    case (w_nxt_step)
      3'd1: begin
        w_nxt_addr = c_ADDR_SEED;
        w_nxt_data = DATA_WIDTH'(r_seed);
      end
      3'd2:    w_nxt_data = DATA_WIDTH'(8'h02);
      3'd3:    w_nxt_data = DATA_WIDTH'(8'h01);
      default: w_nxt_data = '0;
    endcase
  end

  assign w_aw_ok   = !m_axi_awvalid || m_axi_awready;
  assign w_w_ok    = !m_axi_wvalid  || m_axi_wready;
  assign w_cnt_inc = r_sample_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_wstep       <= 3'd0;
      r_seed        <= 8'd0;
      r_count       <= 8'd0;
      r_sample_cnt  <= 8'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed        <= cfg_seed;
            r_count       <= cfg_count;
            r_sample_cnt  <= 8'd0;
            r_wstep       <= 3'd0;
            error         <= 1'b0;
            busy          <= 1'b1;
            m_axi_awaddr  <= c_ADDR_TAPS;
            m_axi_wdata   <= DATA_WIDTH'(cfg_taps);
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            r_state       <= S_WADDR;
          end
        end
        S_WADDR: begin
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            m_axi_bready <= 1'b1;
            r_state      <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              error   <= 1'b1;
              done    <= 1'b1;
              r_state <= S_FINISH;
            end else if (r_wstep == c_STEP_STOP) begin
              done    <= 1'b1;
              r_state <= S_FINISH;
            end else if (r_wstep == c_STEP_ENABLE && r_count != 8'd0) begin
              m_axi_araddr  <= c_ADDR_DATA;
              m_axi_arvalid <= 1'b1;
              r_state       <= S_RADDR;
            end else begin
              r_wstep       <= w_nxt_step;
              m_axi_awaddr  <= w_nxt_addr;
              m_axi_wdata   <= w_nxt_data;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              r_state       <= S_WADDR;
            end
          end
        end
        S_RADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            r_state       <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready  <= 1'b0;
            m_axis_tdata  <= m_axi_rdata;
            m_axis_tvalid <= 1'b1;
            r_state       <= S_PUSH;
          end
        end
        S_PUSH: begin
          // The next read waits for acceptance, so only one sample is ever in flight.
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            r_sample_cnt  <= w_cnt_inc;
            if (w_cnt_inc == r_count) begin
              r_wstep       <= w_nxt_step;
              m_axi_awaddr  <= w_nxt_addr;
              m_axi_wdata   <= w_nxt_data;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              r_state       <= S_WADDR;
            end else begin
              m_axi_arvalid <= 1'b1;
              r_state       <= S_RADDR;
            end
          end
        end
        S_FINISH: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_axi_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_axi_sequencer
// Brief    : Directed bench with an AXI-Lite slave model and stream monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_axi_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cfg_seed = 8'h00;
  logic [7:0] cfg_taps = 8'h00;
  logic [7:0] cfg_count = 8'h00;
  logic       busy, done, error;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic [3:0] m_axi_awaddr, m_axi_araddr;
  logic       m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [7:0] m_axi_wdata, m_axi_rdata;
  logic       m_axi_awready, m_axi_arready;
  logic       m_axi_wready, m_axi_bvalid, m_axi_rvalid;
  logic [1:0] m_axi_bresp;

  assign m_axi_awready = 1'b1;
  assign m_axi_arready = 1'b1;

  lfsr_axi_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_count(cfg_count),
    .busy(busy), .done(done), .error(error),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  logic [7:0] rd_tbl [8] = '{8'h3C, 8'hA5, 8'h7E, 8'h01, 8'hFF, 8'h42, 8'h99, 8'h10};
  logic [3:0] aw_log [$];
  logic [7:0] w_log  [$];
  logic [3:0] ar_log [$];
  logic [7:0] s_log  [$];
  int  done_cnt = 0, b_total = 0, err_at = -1;
  int  stab_err = 0, art_err = 0, ovl_err = 0;
  logic pend_aw, pend_w, prev_tv = 1'b0, prev_acc = 1'b0;
  logic [7:0] prev_td = 8'h00;
  int  n_chk = 0, n_err = 0;

  // Slave: AW/AR always ready, W ready one cycle late, B/R one cycle after the request.
  always @(posedge clk) begin
    if (!resetn) begin
      m_axi_wready <= 1'b0;
      m_axi_bvalid <= 1'b0;
      m_axi_bresp  <= 2'b00;
      m_axi_rvalid <= 1'b0;
      m_axi_rdata  <= 8'h00;
      pend_aw      <= 1'b0;
      pend_w       <= 1'b0;
    end else begin
      m_axi_wready <= m_axi_wvalid && !m_axi_wready;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_log.push_back(m_axi_awaddr);
        pend_aw <= 1'b1;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_log.push_back(m_axi_wdata);
        pend_w <= 1'b1;
      end
      if (pend_aw && pend_w && !m_axi_bvalid) begin
        m_axi_bvalid <= 1'b1;
        m_axi_bresp  <= (b_total == err_at) ? 2'b10 : 2'b00;
        pend_aw      <= 1'b0;
        pend_w       <= 1'b0;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        m_axi_bvalid <= 1'b0;
        b_total      <= b_total + 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rdata  <= rd_tbl[ar_log.size() % 8];
        m_axi_rvalid <= 1'b1;
        ar_log.push_back(m_axi_araddr);
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
    if (done) done_cnt++;
    if (m_axis_tvalid && m_axis_tready) s_log.push_back(m_axis_tdata);
    if (prev_tv && !prev_acc && m_axis_tdata !== prev_td) stab_err++;
    if (m_axi_arvalid && m_axis_tvalid) art_err++;
    if ((m_axi_awvalid || m_axi_wvalid || m_axi_bready) && (m_axi_arvalid || m_axi_rready)) ovl_err++;
    prev_tv  = m_axis_tvalid;
    prev_acc = m_axis_tready;
    prev_td  = m_axis_tdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [7:0] sd, input logic [7:0] tp,
                     input logic [7:0] ct, input bit glitch);
    bit ok = 1'b0;
    @(negedge clk);
    cfg_seed = sd; cfg_taps = tp; cfg_count = ct; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_start"}, busy, 1);
    check({tag, ".err_start"}, error, 0);
    for (int i = 0; i < 400 && !ok; i++) begin
      if (glitch && i == 4) begin
        cfg_seed = ~sd; cfg_taps = ~tp; cfg_count = ct + 8'd2; start = 1'b1;
      end
      if (glitch && i == 5) start = 1'b0;
      if (done) ok = 1'b1;
      else @(negedge clk);
    end
    check({tag, ".done_seen"}, ok, 1);
    @(negedge clk);
    check({tag, ".busy_end"}, busy, 0);
  endtask

  task automatic verify(input string tag, input int a0, input int r0, input int s0, input int d0,
                        input logic [7:0] sd, input logic [7:0] tp, input logic [7:0] ct,
                        input int nwr);
    logic [3:0] ea [5];
    logic [7:0] ed [5];
    int nrd;
    ea = '{4'h8, 4'h4, 4'h0, 4'h0, 4'h0};
    ed = '{tp, sd, 8'h02, 8'h01, 8'h00};
    nrd = (nwr == 5) ? int'(ct) : 0;
    check({tag, ".n_aw"}, aw_log.size() - a0, nwr);
    check({tag, ".n_w"}, w_log.size() - a0, nwr);
    for (int i = 0; i < nwr && a0 + i < aw_log.size() && a0 + i < w_log.size(); i++) begin
      check($sformatf("%s.awaddr%0d", tag, i), aw_log[a0 + i], ea[i]);
      check($sformatf("%s.wdata%0d", tag, i), w_log[a0 + i], ed[i]);
    end
    check({tag, ".n_ar"}, ar_log.size() - r0, nrd);
    check({tag, ".n_smp"}, s_log.size() - s0, nrd);
    for (int i = 0; i < nrd && r0 + i < ar_log.size() && s0 + i < s_log.size(); i++) begin
      check($sformatf("%s.araddr%0d", tag, i), ar_log[r0 + i], 4'hC);
      check($sformatf("%s.smp%0d", tag, i), s_log[s0 + i], rd_tbl[(r0 + i) % 8]);
    end
    check({tag, ".n_done"}, done_cnt - d0, 1);
  endtask

  int a0, r0, s0, d0;
  task automatic mark();
    a0 = aw_log.size(); r0 = ar_log.size(); s0 = s_log.size(); d0 = done_cnt;
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    check("rst.flags", {busy, done, error, m_axis_tvalid, m_axi_awvalid, m_axi_wvalid,
                        m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check("rst.data", {m_axis_tdata, m_axi_wdata}, 0);
    check("rst.addr", {m_axi_awaddr, m_axi_araddr}, 0);
    resetn = 1'b1;

    mark(); run("basic", 8'h19, 8'hB8, 8'd3, 1'b0);
    verify("basic", a0, r0, s0, d0, 8'h19, 8'hB8, 8'd3, 5);

    mark(); run("cnt0", 8'h5A, 8'h33, 8'd0, 1'b0);
    verify("cnt0", a0, r0, s0, d0, 8'h5A, 8'h33, 8'd0, 5);

    mark();
    m_axis_tready = 1'b0;
    fork
      run("stall", 8'h01, 8'h8E, 8'd2, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
          @(negedge clk);
          seen = m_axis_tvalid;
        end
        check("stall.tvalid_seen", seen, 1);
        check("stall.tdata_first", m_axis_tdata, rd_tbl[r0 % 8]);
        repeat (10) @(negedge clk);
        check("stall.tdata_held", m_axis_tdata, rd_tbl[r0 % 8]);
        check("stall.n_ar_held", ar_log.size() - r0, 1);
        m_axis_tready = 1'b1;
      end
    join
    verify("stall", a0, r0, s0, d0, 8'h01, 8'h8E, 8'd2, 5);

    mark(); err_at = b_total + 1;
    run("berr", 8'h77, 8'hC3, 8'd4, 1'b0);
    err_at = -1;
    check("berr.error", error, 1);
    verify("berr", a0, r0, s0, d0, 8'h77, 8'hC3, 8'd4, 2);

    mark(); run("after_err", 8'h22, 8'h44, 8'd1, 1'b0);
    check("after_err.error", error, 0);
    verify("after_err", a0, r0, s0, d0, 8'h22, 8'h44, 8'd1, 5);

    mark(); run("ignore", 8'h6D, 8'h95, 8'd2, 1'b1);
    verify("ignore", a0, r0, s0, d0, 8'h6D, 8'h95, 8'd2, 5);

    mark();
    @(negedge clk);
    cfg_seed = 8'hE1; cfg_taps = 8'h1D; cfg_count = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (m_axi_rready) seen = 1'b1;
      else @(negedge clk);
    end
    check("mrst.rdata_seen", seen, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst.flags", {busy, done, error, m_axis_tvalid, m_axi_awvalid, m_axi_wvalid,
                         m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    check("mrst.data", {m_axis_tdata, m_axi_wdata}, 0);
    check("mrst.addr", {m_axi_awaddr, m_axi_araddr}, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("mrst.n_aw", aw_log.size() - a0, 4);
    check("mrst.n_ar", ar_log.size() - r0, 1);
    check("mrst.n_smp", s_log.size() - s0, 0);
    check("mrst.n_done", done_cnt - d0, 0);

    mark(); run("post_rst", 8'h3B, 8'hA6, 8'd1, 1'b0);
    verify("post_rst", a0, r0, s0, d0, 8'h3B, 8'hA6, 8'd1, 5);

    check("mon.tdata_stable", stab_err, 0);
    check("mon.ar_vs_tvalid", art_err, 0);
    check("mon.rd_wr_overlap", ovl_err, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/lfsr_axi_sequencer.md
LFSR_AXI_SEQUENCER -- requirements
Module: lfsr_axi_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, AXI-Lite data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port start, input, 1, one-cycle run request.
REQ-006 SHALL have ports cfg_seed, cfg_taps and cfg_count, input, 8 each: LFSR seed, tap mask and number of samples; all captured at accepted start.
REQ-007 SHALL have port busy, output, 1, run in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse at run end.
REQ-009 SHALL have port error, output, 1, sticky write-error flag.
REQ-010 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1) and m_axis_tready (input, 1): the sample stream.
REQ-011 SHALL have AXI-Lite master ports m_axi_awaddr/awvalid/awready, wdata/wvalid/wready, bresp[1:0]/bvalid/bready, araddr/arvalid/arready, rdata/rvalid/rready, standard directions, widths per parameters.

Function
REQ-012 SHALL accept start only in IDLE; start while busy SHALL be ignored and SHALL NOT alter the captured config.
REQ-013 Run SHALL issue, in order: write 0x8=taps, write 0x4=seed, write 0x0=0x02 (load), write 0x0=0x01 (enable), cfg_count reads of 0xC, then write 0x0=0x00 (stop).
REQ-014 States SHALL be IDLE, WADDR, WRESP, RADDR, RDATA, PUSH, FINISH; a 3-bit write-step index SHALL select the address/data for WADDR.
REQ-015 WADDR SHALL assert awvalid and wvalid together in the same cycle, with stable addr/data.
REQ-016 In WADDR, each valid SHALL drop on its own handshake (valid&ready); WRESP SHALL be entered once both AW and W have completed.
REQ-017 WRESP SHALL hold bready=1 and consume bvalid.
REQ-018 On a WRESP response with bresp!=2'b00, the sequencer SHALL set error and go to FINISH with no further transactions, including the stop write.
REQ-019 RADDR SHALL assert arvalid until arready; RDATA SHALL hold rready=1 and capture rdata into m_axis_tdata on rvalid.
REQ-020 PUSH SHALL assert m_axis_tvalid until m_axis_tready; the next read SHALL NOT issue until acceptance (no sample loss, at most one sample buffered).
REQ-021 A sample counter SHALL count accepted samples; after cfg_count samples, the sequencer SHALL proceed to the stop write.
REQ-022 cfg_count=0 SHALL perform zero reads: the four config writes then the stop write.
REQ-023 FINISH SHALL pulse done for exactly one cycle, then return to IDLE; busy SHALL be 1 from the cycle after start acceptance until FINISH inclusive.
REQ-024 error SHALL clear on the next accepted start.
REQ-025 At most one AXI transaction SHALL be outstanding; the sequencer SHALL never run reads and writes concurrently.
REQ-026 m_axis_tdata SHALL hold its value while tvalid=1.

Reset
REQ-027 resetn=0 at a clock edge SHALL force IDLE and zero all valids, bready, rready, busy, done, error, the counters, m_axis_tdata and the AXI addr/data outputs.
REQ-028 Reset mid-run SHALL abandon the run immediately without a stop write; the first start after reset release SHALL be accepted.

Verification
REQ-029 seed=0x19, taps=0xB8, count=3, slave OKAY, tready=1 -> writes (8,B8),(4,19),(0,02),(0,01); 3 reads of 0xC; write (0,00); 3 samples equal to the slave rdata; done pulse once.
REQ-030 count=0 -> exactly 5 writes, no ar transaction, no tvalid, done pulse.
REQ-031 count=2 with tready held low for 10 cycles after first tvalid -> tdata stable, no second arvalid until acceptance, both samples delivered in order.
REQ-032 bresp=2'b10 on the seed write -> error=1, no further aw/ar, done pulse; next start -> error=0.
REQ-033 resetn low during RDATA -> all outputs zero next cycle, IDLE, busy=0; new start runs normally.
REQ-034 start pulsed during run with different cfg -> ignored; transactions use the original config.
